reg32_serial_tx: RTL and testbench

//  Unload side of the 32-bit Load/clear register: accepts a parallel word on Load, then shifts
//  it out one bit per accepted beat, LSB first, on a valid/ready serial link.

---
 rtl/reg32_pkg.sv | 12 +
 rtl/bit_counter.sv | 37 +++
 rtl/reg32_serial_tx.sv | 93 +++++++++
 tb/tb_reg32_serial_tx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/reg32_pkg.sv
// rtl/reg32_pkg.sv - shared state encoding and defaults for the serial word transmitter
package reg32_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - bit index counter that saturates at WIDTH-1 and flags the last bit
module bit_counter #(
  parameter int WIDTH = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = (cnt_q == CW'(WIDTH - 1));

  // Holds at the terminal count; only an idle-phase clear brings it back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg32_serial_tx.sv
// rtl/reg32_serial_tx.sv - captures a parallel word and shifts it out on a valid/ready serial link
module reg32_serial_tx
  import reg32_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic             ready,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             done
);

  state_e           state_q;
  logic             ready_q;
  logic             sout_valid_q;
  logic             done_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             beat;
  logic             last_bit;

  assign beat    = (state_q == ST_SHIFT) && sout_ready;
  assign shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk_i (clk),
    .rst_i (clear),
    .clr_i (state_q == ST_IDLE),
    .en_i  (beat),
    .tc_o  (last_bit)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      q_q          <= '0;
      shreg_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Load) begin
            q_q          <= D;
            shreg_q      <= D;
            ready_q      <= 1'b0;
            sout_valid_q <= 1'b1;
            state_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (beat) begin
            shreg_q <= shreg_d;
            if (last_bit) begin
              sout_valid_q <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          sout_valid_q <= 1'b0;
          done_q       <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;
  assign Q          = q_q;
  assign sout       = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: tb/tb_reg32_serial_tx.sv
// tb/tb_reg32_serial_tx.sv - self-checking bench for reg32_serial_tx, both bit orders
module tb_reg32_serial_tx;

  logic        clk = 1'b0;
  logic        clear;
  logic        load;
  logic        sout_ready;
  logic [31:0] d;
  logic        use_b;

  logic        a_ready, a_sout, a_valid, a_done;
  logic [31:0] a_q;
  logic        b_ready, b_sout, b_valid, b_done;
  logic [31:0] b_q;

  logic        m_ready, m_sout, m_valid, m_done;
  logic [31:0] m_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg32_serial_tx #(.WIDTH(32), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .clear(clear), .D(d), .Load(load), .ready(a_ready), .Q(a_q),
    .sout(a_sout), .sout_valid(a_valid), .sout_ready(sout_ready), .done(a_done)
  );

  reg32_serial_tx #(.WIDTH(32), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .clear(clear), .D(d), .Load(load), .ready(b_ready), .Q(b_q),
    .sout(b_sout), .sout_valid(b_valid), .sout_ready(sout_ready), .done(b_done)
  );

  assign m_ready = use_b ? b_ready : a_ready;
  assign m_sout  = use_b ? b_sout  : a_sout;
  assign m_valid = use_b ? b_valid : a_valid;
  assign m_done  = use_b ? b_done  : a_done;
  assign m_q     = use_b ? b_q     : a_q;

  typedef struct {
    logic [31:0] w;
    int          mode;
    bit          msb;
    int          exp_edges;
    int          inject_at;
    logic [31:0] w2;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always 1, 1: ready 0,1,0,1..., 2: random ready
  task automatic run_xfer(input logic [31:0] w, input int mode, input bit msb,
                          input int exp_edges, input int inject_at, input logic [31:0] w2);
    logic [31:0] got;
    int nbits, edges, hold_err, q_err, misc_err;
    bit tog, stall, pbit, rdy;
    use_b = msb;
    #0;
    check("idle_ready", 32'(m_ready), 32'd1);
    d = w; load = 1'b1; sout_ready = 1'b0;
    tick();
    load = 1'b0;
    got = '0; nbits = 0; edges = 0; hold_err = 0; q_err = 0; misc_err = 0;
    tog = 1'b0; stall = 1'b0; pbit = 1'b0;
    while (nbits < 32 && edges < 2000) begin
      if (stall && m_sout !== pbit) hold_err++;
      if (m_q !== w) q_err++;
      if (m_done !== 1'b0 || m_ready !== 1'b0 || m_valid !== 1'b1) misc_err++;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      sout_ready = rdy;
      load = (inject_at >= 0 && nbits == inject_at);
      d = load ? w2 : w;
      if (m_valid && rdy) begin
        if (msb) got[31 - nbits] = m_sout;
        else     got[nbits]      = m_sout;
        nbits++;
      end
      stall = m_valid && !rdy;
      pbit  = m_sout;
      tick();
      edges++;
    end
    load = 1'b0; sout_ready = 1'b0;
    check("bits_complete", 32'(nbits), 32'd32);
    check("word_reassembled", got, w);
    check("hold_on_stall", 32'(hold_err), 32'd0);
    check("q_stable", 32'(q_err), 32'd0);
    check("shift_flags", 32'(misc_err), 32'd0);
    if (exp_edges >= 0) check("beat_edges", 32'(edges), 32'(exp_edges));
    check("done_pulse", {29'd0, m_done, m_valid, m_ready}, 32'b100);
    tick();
    check("done_end", {29'd0, m_done, m_valid, m_ready}, 32'b001);
    check("q_after", m_q, w);
  endtask

  initial begin
    int bad_done;
    logic [31:0] aw;
    clear = 1'b1; load = 1'b0; d = '0; sout_ready = 1'b0; use_b = 1'b0;
    tick();
    tick();
    check("rst_a_flags", {28'd0, a_ready, a_valid, a_done, a_sout}, 32'b1000);
    check("rst_a_q", a_q, 32'd0);
    check("rst_b_flags", {28'd0, b_ready, b_valid, b_done, b_sout}, 32'b1000);
    check("rst_b_q", b_q, 32'd0);
    clear = 1'b0;

    vecs[0] = '{32'hAAAAAAAA, 0, 1'b0, 32, -1, 32'h0};
    vecs[1] = '{32'h55555555, 1, 1'b0, 64, -1, 32'h0};
    vecs[2] = '{32'hA5A5A5A5, 0, 1'b0, 32,  5, 32'h5A5A5A5A};
    vecs[3] = '{32'h80000001, 0, 1'b1, 32, -1, 32'h0};
    vecs[4] = '{32'hFFFFFFFF, 1, 1'b1, 64, -1, 32'h0};
    vecs[5] = '{32'h00000001, 2, 1'b0, -1, -1, 32'h0};
    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].w, vecs[i].mode, vecs[i].msb, vecs[i].exp_edges,
               vecs[i].inject_at, vecs[i].w2);
    end

    // Abort at bit 10, then a fresh word must start from bit 0.
    use_b = 1'b0;
    aw = 32'hA5A5A5A5;
    d = aw; load = 1'b1;
    tick();
    load = 1'b0; sout_ready = 1'b1;
    repeat (10) tick();
    check("abort_bit10", {30'd0, m_valid, m_sout}, {30'd0, 1'b1, aw[10]});
    clear = 1'b1;
    tick();
    clear = 1'b0; sout_ready = 1'b0;
    check("abort_flags", {28'd0, m_done, m_valid, m_ready, m_sout}, 32'b0010);
    check("abort_q", m_q, 32'd0);
    bad_done = 0;
    repeat (4) begin
      if (m_done !== 1'b0 || m_valid !== 1'b0) bad_done++;
      tick();
    end
    check("abort_quiet", 32'(bad_done), 32'd0);
    run_xfer(32'h5A5A5A5A, 0, 1'b0, 32, -1, 32'h0);

    // clear and Load together from idle: nothing captured.
    clear = 1'b1; load = 1'b1; d = 32'hDEADBEEF;
    tick();
    clear = 1'b0; load = 1'b0;
    check("clr_load_q", m_q, 32'd0);
    check("clr_load_flags", {29'd0, m_done, m_valid, m_ready}, 32'b001);
    tick();
    check("clr_load_valid", 32'(m_valid), 32'd0);

    for (int i = 0; i < 100; i++) run_xfer($urandom, 2, 1'b1, -1, -1, 32'h0);
    for (int i = 0; i < 20; i++)  run_xfer($urandom, 2, 1'b0, -1, -1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
